// File: rtl/div_pkg.sv
// Shared definitions for the fixed-point handshake divider.
//   div_state_e : controller states (IDLE, CALC, FIX, DONE)
//   div_iter    : number of restoring steps for a WIDTH/FBITS format
//   div_cnt_w   : width of the step counter
//   abs_mag     : magnitude of a sign-extended operand
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Widest operand abs_mag can handle; callers extend into this width.
  localparam int unsigned DIV_MAXW = 64;

  function automatic int unsigned div_iter(input int unsigned width,
                                           input int unsigned fbits);
    return width + fbits;
  endfunction

  function automatic int unsigned div_cnt_w(input int unsigned width,
                                            input int unsigned fbits);
    return $clog2(width + fbits + 1);
  endfunction

  // Value must already be sign-extended to DIV_MAXW when signed_mode is set,
  // so the most negative WIDTH-bit input yields 2^(WIDTH-1) in its low bits.
  function automatic logic [DIV_MAXW-1:0] abs_mag(input logic [DIV_MAXW-1:0] value,
                                                  input logic                signed_mode);
    if (signed_mode && value[DIV_MAXW-1]) begin
      return -value;
    end
    return value;
  endfunction

endpackage

// File: rtl/div_fp_hs_step.sv
// One combinational restoring-division step.
//   acc      : partial remainder (WIDTH+1 bits)
//   q        : dividend bits still to be consumed (MSB first), with quotient
//              bits accumulating at the LSB end
//   y        : divisor magnitude
//   acc_next : partial remainder after this step
//   q_next   : q shifted left by one with the new quotient bit at bit 0
module div_step_u #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 16
) (
  input  logic [WIDTH:0]   acc,
  input  logic [ITER-1:0]  q,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH:0]   acc_next,
  output logic [ITER-1:0]  q_next
);

  logic [WIDTH:0] trial;
  logic           fits;

  always_comb begin
    trial = {acc[WIDTH-1:0], q[ITER-1]};
    // acc stays below y between steps, so its top bit is normally clear;
    // if it were ever set the shifted value would certainly exceed y.
    fits     = acc[WIDTH] || (trial >= {1'b0, y});
    acc_next = fits ? (trial - {1'b0, y}) : trial;
    q_next   = {q[ITER-2:0], fits};
  end

endmodule

// File: rtl/div_fp_hs.sv
// Multi-cycle fixed-point restoring divider with ready/valid handshakes.
// Fixed latency of WIDTH+FBITS+2 cycles for a non-zero divisor, one cycle for
// a zero divisor; the result is held until the consumer takes it.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_valid, o_ready  : operand handshake (o_ready combinational from i_ready)
//   i_x, i_y          : dividend, divisor (WIDTH bits)
//   o_valid, i_ready  : result handshake
//   o_q, o_r          : quotient, remainder (remainder takes dividend sign)
//   o_dbz, o_ovf      : divide-by-zero / overflow flags, qualified by o_valid
module div_fp_hs
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FBITS  = 0,
  parameter int unsigned SIGNED = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam int unsigned ITER  = div_iter(WIDTH, FBITS);
  localparam int unsigned CNT_W = div_cnt_w(WIDTH, FBITS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

  // Overflow limits on the zero-extended ITER-bit magnitude quotient.
  localparam logic [ITER:0] ONE_X = (ITER + 1)'(1);
  localparam logic [ITER:0] LIM_U = (ONE_X << WIDTH) - ONE_X;
  localparam logic [ITER:0] LIM_N = ONE_X << (WIDTH - 1);
  localparam logic [ITER:0] LIM_P = LIM_N - ONE_X;

  localparam logic SMODE = (SIGNED != 0);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_q;
  logic [ITER-1:0]  qr_q;
  logic [WIDTH-1:0] ym_q;
  logic             sx_q, sy_q;

  logic             accept, step_en, fix_en;
  logic             y_zero;
  logic [DIV_MAXW-1:0] x_ext, y_ext;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic             x_neg, y_neg;

  logic [WIDTH:0]   acc_nx;
  logic [ITER-1:0]  qr_nx;

  logic [ITER:0]    qm_ext;
  logic             res_neg;
  logic             fix_ovf;
  logic [WIDTH-1:0] fix_q, fix_r, rm;

  // Operand conditioning at accept time.
  always_comb begin
    y_zero = (i_y == '0);
    x_neg  = SMODE && i_x[WIDTH-1];
    y_neg  = SMODE && i_y[WIDTH-1];
    if (SMODE) begin
      x_ext = DIV_MAXW'($signed(i_x));
      y_ext = DIV_MAXW'($signed(i_y));
    end else begin
      x_ext = DIV_MAXW'(i_x);
      y_ext = DIV_MAXW'(i_y);
    end
    x_mag = WIDTH'(abs_mag(x_ext, SMODE));
    y_mag = WIDTH'(abs_mag(y_ext, SMODE));
  end

  div_step_u #(
    .WIDTH(WIDTH),
    .ITER (ITER)
  ) u_step (
    .acc     (acc_q),
    .q       (qr_q),
    .y       (ym_q),
    .acc_next(acc_nx),
    .q_next  (qr_nx)
  );

  // Sign/overflow fix-up of the magnitude result.
  always_comb begin
    qm_ext  = {1'b0, qr_q};
    res_neg = sx_q ^ sy_q;
    rm      = acc_q[WIDTH-1:0];
    if (!SMODE) begin
      fix_ovf = (qm_ext > LIM_U);
    end else if (res_neg) begin
      fix_ovf = (qm_ext > LIM_N);
    end else begin
      fix_ovf = (qm_ext > LIM_P);
    end
    fix_q = res_neg ? -qr_q[WIDTH-1:0] : qr_q[WIDTH-1:0];
    fix_r = sx_q ? -rm : rm;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    fix_en  = 1'b0;
    o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    o_valid = (state_q == DONE);
    accept  = i_valid && o_ready;
    case (state_q)
      IDLE: begin
        if (accept) state_d = y_zero ? DONE : CALC;
      end
      CALC: begin
        step_en = 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        fix_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (accept) begin
          state_d = y_zero ? DONE : CALC;
        end else if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      qr_q  <= '0;
      ym_q  <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      o_q   <= '0;
      o_r   <= '0;
      o_dbz <= 1'b0;
      o_ovf <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      acc_q <= '0;
      o_q   <= '0;
      o_r   <= '0;
      o_ovf <= 1'b0;
      o_dbz <= y_zero;
      if (y_zero) begin
        qr_q <= '0;
        ym_q <= '0;
        sx_q <= 1'b0;
        sy_q <= 1'b0;
      end else begin
        // The dividend shifts out of the top of qr_q while quotient bits
        // fill in from the bottom, so one register serves both roles.
        qr_q <= ITER'(x_mag) << FBITS;
        ym_q <= y_mag;
        sx_q <= x_neg;
        sy_q <= y_neg;
      end
    end else if (step_en) begin
      acc_q <= acc_nx;
      qr_q  <= qr_nx;
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (fix_en) begin
      o_ovf <= fix_ovf;
      o_q   <= fix_ovf ? '0 : fix_q;
      o_r   <= fix_ovf ? '0 : fix_r;
    end
  end

endmodule

// File: tb/tb_div_fp_hs.sv
module tb_div_fp_hs;

  typedef struct {
    logic [1:0] s;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tv = 1'b0;
  logic tr = 1'b1;
  logic [7:0] tx = '0;
  logic [7:0] ty = '0;
  logic [1:0] sel = '0;

  logic [2:0] iv, ir, ov, ordy, dbz_a, ovf_a;
  logic [2:0][7:0] q_a, r_a;

  logic vvalid, vready, vdbz, vovf;
  logic [7:0] vq, vr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iv     = tv ? (3'b001 << sel) : 3'b000;
  assign ir     = tr ? (3'b001 << sel) : 3'b000;
  assign vvalid = ov[sel];
  assign vready = ordy[sel];
  assign vq     = q_a[sel];
  assign vr     = r_a[sel];
  assign vdbz   = dbz_a[sel];
  assign vovf   = ovf_a[sel];

  // sel 0: unsigned Q4.4, sel 1: signed integer, sel 2: signed Q4.4
  div_fp_hs #(.WIDTH(8), .FBITS(4), .SIGNED(0)) u_u84 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[0]), .o_ready(ordy[0]),
    .i_x(tx), .i_y(ty), .o_valid(ov[0]), .i_ready(ir[0]),
    .o_q(q_a[0]), .o_r(r_a[0]), .o_dbz(dbz_a[0]), .o_ovf(ovf_a[0]));

  div_fp_hs #(.WIDTH(8), .FBITS(0), .SIGNED(1)) u_s80 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[1]), .o_ready(ordy[1]),
    .i_x(tx), .i_y(ty), .o_valid(ov[1]), .i_ready(ir[1]),
    .o_q(q_a[1]), .o_r(r_a[1]), .o_dbz(dbz_a[1]), .o_ovf(ovf_a[1]));

  div_fp_hs #(.WIDTH(8), .FBITS(4), .SIGNED(1)) u_s84 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[2]), .o_ready(ordy[2]),
    .i_x(tx), .i_y(ty), .o_valid(ov[2]), .i_ready(ir[2]),
    .o_q(q_a[2]), .o_r(r_a[2]), .o_dbz(dbz_a[2]), .o_ovf(ovf_a[2]));

  // Present operands and hold them until the accepting edge has passed.
  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    @(negedge clk);
    tx = x;
    ty = y;
    tv = 1'b1;
    #1;
    while (!vready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (vready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait sel=%0d o_ready=%b required 1", sel, vready);
    end
    @(posedge clk);
    #1 tv = 1'b0;
  endtask

  // Latency: number of edges from the accept edge up to the one that
  // first samples o_valid high (1 = visible straight after accept).
  task automatic wait_valid(output int n);
    n = 1;
    @(negedge clk);
    while (!vvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if ({vvalid, vready} !== 2'b01) begin
        errors++;
        $display("FAIL reset_hs sel=%0d valid,ready=%b required 01", s, {vvalid, vready});
      end
      checks++;
      if ({vq, vr, vdbz, vovf} !== 18'h0) begin
        errors++;
        $display("FAIL reset_out sel=%0d q=%h r=%h dbz=%b ovf=%b required all 0",
                 s, vq, vr, vdbz, vovf);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t v[$]);
    int n;
    foreach (v[i]) begin
      sel = v[i].s;
      accept(v[i].x, v[i].y);
      wait_valid(n);
      checks++;
      if (n != v[i].lat) begin
        errors++;
        $display("FAIL %s_lat[%0d] latency=%0d required %0d", name, i, n, v[i].lat);
      end
      checks++;
      if ({vvalid, vq, vr, vdbz, vovf} !== {1'b1, v[i].q, v[i].r, v[i].dbz, v[i].ovf}) begin
        errors++;
        $display("FAIL %s_res[%0d] x=%h y=%h got v=%b q=%h r=%h dbz=%b ovf=%b required v=1 q=%h r=%h dbz=%b ovf=%b",
                 name, i, v[i].x, v[i].y, vvalid, vq, vr, vdbz, vovf,
                 v[i].q, v[i].r, v[i].dbz, v[i].ovf);
      end
      @(negedge clk);
      checks++;
      if (vvalid !== 1'b0) begin
        errors++;
        $display("FAIL %s_consume[%0d] o_valid=%b required 0", name, i, vvalid);
      end
    end
  endtask

  task automatic test_unsigned_frac;
    vec_t v[$];
    v.push_back(vec_t'{2'd0, 8'h30, 8'h20, 8'h18, 8'h00, 1'b0, 1'b0, 14});
    v.push_back(vec_t'{2'd0, 8'h37, 8'h20, 8'h1B, 8'h10, 1'b0, 1'b0, 14});
    v.push_back(vec_t'{2'd0, 8'h0F, 8'h01, 8'hF0, 8'h00, 1'b0, 1'b0, 14});
    run_table("ufrac", v);
  endtask

  task automatic test_signed_int;
    vec_t v[$];
    v.push_back(vec_t'{2'd1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 10});
    v.push_back(vec_t'{2'd1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 10});
    v.push_back(vec_t'{2'd1, 8'hFA, 8'h04, 8'hFF, 8'hFE, 1'b0, 1'b0, 10});
    v.push_back(vec_t'{2'd1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 10});
    v.push_back(vec_t'{2'd1, 8'h80, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 10});
    run_table("sint", v);
  endtask

  task automatic test_overflow;
    vec_t v[$];
    v.push_back(vec_t'{2'd0, 8'h80, 8'h04, 8'h00, 8'h00, 1'b0, 1'b1, 14});
    v.push_back(vec_t'{2'd0, 8'h10, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 14});
    v.push_back(vec_t'{2'd2, 8'h80, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b1, 14});
    v.push_back(vec_t'{2'd2, 8'h80, 8'h10, 8'h80, 8'h00, 1'b0, 1'b0, 14});
    v.push_back(vec_t'{2'd2, 8'hE8, 8'h20, 8'hF4, 8'h00, 1'b0, 1'b0, 14});
    run_table("ovf", v);
  endtask

  task automatic test_dbz;
    vec_t v[$];
    v.push_back(vec_t'{2'd0, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1});
    v.push_back(vec_t'{2'd1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1});
    v.push_back(vec_t'{2'd2, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1});
    run_table("dbz", v);
  endtask

  task automatic test_back_to_back;
    int n;
    sel = 2'd0;
    tr  = 1'b0;
    accept(8'h30, 8'h20);
    wait_valid(n);
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL hold_lat latency=%0d required 14", n);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({vvalid, vready, vq, vr, vdbz, vovf} !== {2'b10, 8'h18, 8'h00, 2'b00}) begin
        errors++;
        $display("FAIL hold[%0d] v=%b rdy=%b q=%h r=%h dbz=%b ovf=%b required v=1 rdy=0 q=18 r=00 dbz=0 ovf=0",
                 c, vvalid, vready, vq, vr, vdbz, vovf);
      end
    end
    // Consume and present the next operands on the same edge.
    tr = 1'b1;
    tx = 8'h40;
    ty = 8'h20;
    tv = 1'b1;
    #1;
    checks++;
    if (vready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready o_ready=%b required 1", vready);
    end
    @(posedge clk);
    #1 tv = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL b2b_lat latency=%0d required 14", n);
    end
    checks++;
    if ({vq, vr, vdbz, vovf} !== {8'h20, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL b2b_res q=%h r=%h dbz=%b ovf=%b required q=20 r=00 dbz=0 ovf=0",
               vq, vr, vdbz, vovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int  n;
    logic seen;
    sel = 2'd0;
    accept(8'h30, 8'h20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (vvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid o_valid=%b required 0", vvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({vvalid, vready} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_release valid,ready=%b required 01", {vvalid, vready});
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | vvalid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale o_valid seen=%b required 0", seen);
    end
    accept(8'h37, 8'h20);
    wait_valid(n);
    checks++;
    if (n != 14 || {vq, vr, vdbz, vovf} !== {8'h1B, 8'h10, 2'b00}) begin
      errors++;
      $display("FAIL midrst_after latency=%0d q=%h r=%h dbz=%b ovf=%b required 14 q=1B r=10 dbz=0 ovf=0",
               n, vq, vr, vdbz, vovf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_unsigned_frac;
    test_signed_int;
    test_overflow;
    test_dbz;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
